// File: rtl/nn_input_streamer_if.sv
// Write port, start/abort control and valid/ready pixel stream of nn_input_streamer.
// The master modport is the streamer side; slave is the loader/consumer side.
interface nn_input_streamer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_SIZE   = 784,
  parameter int NUM_IMGS   = 4,
  parameter int LANES      = 1
);
  localparam int ADDR_W = (NUM_IMGS * IMG_SIZE > 1) ? $clog2(NUM_IMGS * IMG_SIZE) : 1;
  localparam int SEL_W  = (NUM_IMGS > 1) ? $clog2(NUM_IMGS) : 1;

  logic                        wr_en;
  logic [ADDR_W-1:0]           wr_addr;
  logic [DATA_WIDTH-1:0]       wr_data;
  logic                        start;
  logic [SEL_W-1:0]            img_sel;
  logic                        abort;
  logic                        busy;
  logic                        m_valid;
  logic                        m_ready;
  logic [LANES*DATA_WIDTH-1:0] m_data;
  logic                        m_last;
  logic                        done;
  logic                        err;

  modport master (
    input  wr_en, wr_addr, wr_data, start, img_sel, abort, m_ready,
    output busy, m_valid, m_data, m_last, done, err
  );

  modport slave (
    output wr_en, wr_addr, wr_data, start, img_sel, abort, m_ready,
    input  busy, m_valid, m_data, m_last, done, err
  );
endinterface

// File: rtl/nn_input_streamer.sv
// Multi-slot image buffer that streams one selected image, LANES pixels per beat,
// over a valid/ready interface with backpressure, last-beat flag and done/err pulses.
module nn_input_streamer #(
  parameter int    DATA_WIDTH = 16,
  parameter int    IMG_SIZE   = 784,
  parameter int    NUM_IMGS   = 4,
  parameter int    LANES      = 1,
  parameter string INIT_FILE  = "input_nn.mem"
) (
  input logic                clk,
  input logic                rst_n,
  nn_input_streamer_if.master bus
);
  localparam int TOTAL  = NUM_IMGS * IMG_SIZE;
  localparam int BEATS  = IMG_SIZE / LANES;
  localparam int ADDR_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int SEL_W  = (NUM_IMGS > 1) ? $clog2(NUM_IMGS) : 1;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WORD_W = LANES * DATA_WIDTH;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t state, next_state;

  logic [DATA_WIDTH-1:0] mem [TOTAL];

  logic [SEL_W-1:0]  slot;
  logic [CNT_W-1:0]  beat_cnt;
  logic              m_valid_q;
  logic              m_last_q;
  logic [WORD_W-1:0] m_data_q;
  logic              done_q;
  logic              err_q;

  logic              sel_ok;
  logic              load;
  logic              clear;
  logic              done_next;
  logic              err_next;
  logic [SEL_W-1:0]  rd_slot;
  int                rd_beat;
  logic [WORD_W-1:0] rd_word;

  // The select is widened before comparing so non-power-of-two slot counts are caught.
  always_comb begin
    sel_ok = 32'(bus.img_sel) < NUM_IMGS;
  end

  // Next-state and control: the output register loads beat 0 directly from the start cycle,
  // then the following beat on every non-final handshake.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    clear      = 1'b0;
    done_next  = 1'b0;
    err_next   = 1'b0;
    rd_slot    = slot;
    rd_beat    = int'(beat_cnt) + 1;
    case (state)
      IDLE: begin
        rd_slot = bus.img_sel;
        rd_beat = 0;
        if (bus.start) begin
          if (sel_ok) begin
            next_state = STREAM;
            load       = 1'b1;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      STREAM: begin
        err_next = bus.start;
        if (bus.abort) begin
          next_state = IDLE;
          clear      = 1'b1;
        end else if (m_valid_q && bus.m_ready) begin
          if (m_last_q) begin
            next_state = IDLE;
            clear      = 1'b1;
            done_next  = 1'b1;
          end else begin
            load = 1'b1;
          end
        end
      end
    endcase
  end

  // Combinational read so a same-cycle write lands after the beat is captured.
  always_comb begin
    rd_word = '0;
    for (int k = 0; k < LANES; k++) begin
      rd_word[k*DATA_WIDTH +: DATA_WIDTH] =
        mem[ADDR_W'(int'(rd_slot) * IMG_SIZE + rd_beat * LANES + k)];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot      <= '0;
      beat_cnt  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= done_next;
      err_q  <= err_next;
      if (load && state == IDLE) begin
        slot <= rd_slot;
      end
      if (load) begin
        m_data_q  <= rd_word;
        m_valid_q <= 1'b1;
        m_last_q  <= (rd_beat == BEATS - 1);
        beat_cnt  <= CNT_W'(rd_beat);
      end else if (clear) begin
        m_valid_q <= 1'b0;
        m_last_q  <= 1'b0;
      end
    end
  end

  // Pixel storage is deliberately left out of reset so images survive a reset.
  always_ff @(posedge clk) begin
    if (bus.wr_en && 32'(bus.wr_addr) < TOTAL) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  assign bus.busy    = (state == STREAM);
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_last  = m_last_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
endmodule

// File: tb/tb_nn_input_streamer.sv
// Directed bench for nn_input_streamer: 2 slots of 8 pixels, 2 lanes, 16-bit pixels.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_nn_input_streamer;
  localparam int DW    = 16;
  localparam int IMG   = 8;
  localparam int NIMG  = 2;
  localparam int LN    = 2;
  localparam int BEATS = IMG / LN;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   check_count = 0;
  int   error_count = 0;
  logic [DW-1:0] mem_model [NIMG*IMG];

  always #5 clk = ~clk;

  nn_input_streamer_if #(.DATA_WIDTH(DW), .IMG_SIZE(IMG), .NUM_IMGS(NIMG), .LANES(LN)) bus ();

  nn_input_streamer #(
    .DATA_WIDTH(DW), .IMG_SIZE(IMG), .NUM_IMGS(NIMG), .LANES(LN), .INIT_FILE("")
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_beat(input int slot, input int beat);
    if (beat < 0 || beat >= BEATS) return 32'h0;
    return {mem_model[slot*IMG + beat*LN + 1], mem_model[slot*IMG + beat*LN]};
  endfunction

  task automatic write_pixel(input int addr, input logic [DW-1:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 4'(addr);
    bus.wr_data = data;
    tick();
    bus.wr_en = 1'b0;
    mem_model[addr] = data;
  endtask

  task automatic applyStimulus(input int sel);
    bus.start   = 1'b1;
    bus.img_sel = 1'(sel);
    tick();
    bus.start = 1'b0;
  endtask

  // Consumes the rest of a stream from beat first_beat; stall selects ready pattern 1,0,0,1,0,0...
  task automatic run_stream(input string tag, input int slot, input bit stall, input int first_beat);
    int beat = first_beat;
    int cyc = 0;
    bit finished = 1'b0;
    while (!finished && cyc < 60) begin
      bus.m_ready = stall ? (cyc % 3 == 0) : 1'b1;
      if (bus.m_valid) begin
        checkOutput({tag, "_data"}, bus.m_data, exp_beat(slot, beat));
        checkOutput({tag, "_last"}, bus.m_last, beat == BEATS - 1);
        if (bus.m_ready) begin
          if (beat == BEATS - 1) finished = 1'b1;
          beat++;
        end
      end
      tick();
      cyc++;
    end
    bus.m_ready = 1'b0;
    checkOutput({tag, "_finished"}, finished, 1'b1);
    checkOutput({tag, "_beats"}, beat, BEATS);
    checkOutput({tag, "_done"}, bus.done, 1'b1);
    checkOutput({tag, "_valid_off"}, bus.m_valid, 1'b0);
    checkOutput({tag, "_busy_off"}, bus.busy, 1'b0);
    tick();
    checkOutput({tag, "_done_pulse"}, bus.done, 1'b0);
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.start   = 1'b0;
    bus.img_sel = '0;
    bus.abort   = 1'b0;
    bus.m_ready = 1'b0;
    #1;
    checkOutput("rst_valid", bus.m_valid, 1'b0);
    checkOutput("rst_busy", bus.busy, 1'b0);
    checkOutput("rst_data", bus.m_data, 32'h0);
    checkOutput("rst_flags", {bus.m_last, bus.done, bus.err}, 3'b000);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    for (int p = 0; p < IMG; p++) write_pixel(IMG + p, 16'(16'h100 + p));
    for (int p = 0; p < IMG; p++) write_pixel(p, 16'(16'h200 + p));

    // Full-rate stream of slot 1.
    applyStimulus(1);
    checkOutput("t1_first_valid", bus.m_valid, 1'b1);
    checkOutput("t1_busy", bus.busy, 1'b1);
    checkOutput("t1_first_data", bus.m_data, 32'h0101_0100);
    run_stream("t1", 1, 1'b0, 0);

    // Same stream under backpressure.
    applyStimulus(1);
    run_stream("t2", 1, 1'b1, 0);

    // With two slots img_sel is one bit wide, so only in-range selects can be driven.
    applyStimulus(1);
    bus.start   = 1'b1;
    bus.img_sel = 1'b0;
    tick();
    bus.start = 1'b0;
    checkOutput("t3_err_busy", bus.err, 1'b1);
    checkOutput("t3_still_busy", bus.busy, 1'b1);
    checkOutput("t3_data_held", bus.m_data, 32'h0101_0100);
    tick();
    checkOutput("t3_err_pulse", bus.err, 1'b0);
    run_stream("t3", 1, 1'b0, 0);

    // Start during the last-beat handshake is still rejected as busy.
    applyStimulus(1);
    bus.m_ready = 1'b1;
    tick();
    tick();
    tick();
    checkOutput("t3_last_beat", {bus.m_last, bus.m_data}, {1'b1, 32'h0107_0106});
    bus.start   = 1'b1;
    bus.img_sel = 1'b0;
    tick();
    bus.start   = 1'b0;
    bus.m_ready = 1'b0;
    checkOutput("t3_late_err", bus.err, 1'b1);
    checkOutput("t3_late_done", bus.done, 1'b1);
    checkOutput("t3_late_busy", bus.busy, 1'b0);
    tick();
    checkOutput("t3_late_idle_valid", bus.m_valid, 1'b0);

    // Abort in IDLE has no effect.
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    checkOutput("t4_idle_abort", {bus.busy, bus.m_valid, bus.err}, 3'b000);

    // Abort after beats 0 and 1 transferred.
    applyStimulus(0);
    bus.m_ready = 1'b1;
    tick();
    tick();
    checkOutput("t4_beat2", bus.m_data, 32'h0205_0204);
    bus.m_ready = 1'b0;
    bus.abort   = 1'b1;
    tick();
    bus.abort = 1'b0;
    checkOutput("t4_abort_state", {bus.m_valid, bus.m_last, bus.busy, bus.done}, 4'b0000);
    tick();
    checkOutput("t4_no_done", bus.done, 1'b0);
    applyStimulus(0);
    checkOutput("t4_restart_data", bus.m_data, 32'h0201_0200);
    run_stream("t4", 0, 1'b0, 0);

    // Asynchronous reset mid-stream, memory retained.
    applyStimulus(1);
    bus.m_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_valid", bus.m_valid, 1'b0);
    checkOutput("t5_rst_busy", bus.busy, 1'b0);
    checkOutput("t5_rst_data", bus.m_data, 32'h0);
    checkOutput("t5_rst_flags", {bus.m_last, bus.done, bus.err}, 3'b000);
    bus.m_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("t5_no_done", bus.done, 1'b0);
    applyStimulus(1);
    run_stream("t5", 1, 1'b0, 0);

    // Write to the pixel being loaded returns the old value for that beat.
    applyStimulus(1);
    bus.m_ready = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_addr = 4'(IMG + 2);
    bus.wr_data = 16'hBEEF;
    tick();
    bus.wr_en = 1'b0;
    checkOutput("t6_old_value", bus.m_data, 32'h0103_0102);
    run_stream("t6a", 1, 1'b0, 1);
    mem_model[IMG + 2] = 16'hBEEF;
    applyStimulus(1);
    bus.m_ready = 1'b1;
    tick();
    checkOutput("t6_new_value", bus.m_data, 32'h0103_BEEF);
    run_stream("t6b", 1, 1'b0, 1);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end
endmodule
